prog_clk_divider: RTL and testbench

//   Parametrised programmable clock divider / tone generator; successor to the fixed-preset

---
 rtl/prog_clk_divider_if.sv | 36 +++
 rtl/prog_clk_divider.sv | 147 ++++++++++++++
 tb/tb_prog_clk_divider.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle between the config logic and prog_clk_divider.
// CLKDIV_DUTY_EN adds the duty_in / pwm_out pair.
interface prog_clk_divider_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] div_in;
   logic             tick;
   logic             sq_out;
   logic [WIDTH-1:0] cnt_o;
   logic             pend_o;
`ifdef CLKDIV_DUTY_EN
   logic [WIDTH-1:0] duty_in;
   logic             pwm_out;

   modport master (
      output en, clr, load, div_in, duty_in,
      input  tick, sq_out, cnt_o, pend_o, pwm_out
   );
   modport slave (
      input  en, clr, load, div_in, duty_in,
      output tick, sq_out, cnt_o, pend_o, pwm_out
   );
`else
   modport master (
      output en, clr, load, div_in,
      input  tick, sq_out, cnt_o, pend_o
   );
   modport slave (
      input  en, clr, load, div_in,
      output tick, sq_out, cnt_o, pend_o
   );
`endif
endinterface

// File: rtl/prog_clk_divider.sv
// Programmable clock divider: wrap-at-T counter, one-cycle tick, 50% square wave, shadowed divisor.
// Optional PWM output when CLKDIV_DUTY_EN is defined.
module prog_clk_divider #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(9)
) (
   input logic              clk,
   input logic              rst_n,
   prog_clk_divider_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0] div_act_r, div_act_nxt_s;
   logic [WIDTH-1:0] div_pend_r, div_pend_nxt_s;
   logic             pend_r, pend_nxt_s;
   logic             tick_r, tick_nxt_s;
   logic             sq_r, sq_nxt_s;
`ifdef CLKDIV_DUTY_EN
   logic [WIDTH-1:0] duty_act_r, duty_act_nxt_s;
   logic [WIDTH-1:0] duty_pend_r, duty_pend_nxt_s;
   logic             pwm_r, pwm_nxt_s;
`endif

   // Next-state logic: clr beats counting; loads apply at a wrap or at once when not counting.
   always_comb begin
      cnt_nxt_s      = cnt_r;
      div_act_nxt_s  = div_act_r;
      div_pend_nxt_s = div_pend_r;
      pend_nxt_s     = pend_r;
      tick_nxt_s     = 1'b0;
      sq_nxt_s       = sq_r;
`ifdef CLKDIV_DUTY_EN
      duty_act_nxt_s  = duty_act_r;
      duty_pend_nxt_s = duty_pend_r;
`endif
      if (bus.clr) begin
         cnt_nxt_s = '0;
         sq_nxt_s  = 1'b0;
         if (bus.load) begin
            div_act_nxt_s  = bus.div_in;
            div_pend_nxt_s = bus.div_in;
            pend_nxt_s     = 1'b0;
`ifdef CLKDIV_DUTY_EN
            duty_act_nxt_s  = bus.duty_in;
            duty_pend_nxt_s = bus.duty_in;
`endif
         end else begin
            pend_nxt_s = pend_r;
         end
      end else if (bus.en) begin
         if (cnt_r == div_act_r) begin
            cnt_nxt_s  = '0;
            tick_nxt_s = 1'b1;
            sq_nxt_s   = ~sq_r;
            // A load on the wrap cycle overrides any older pending value.
            if (bus.load) begin
               div_act_nxt_s  = bus.div_in;
               div_pend_nxt_s = bus.div_in;
               pend_nxt_s     = 1'b0;
`ifdef CLKDIV_DUTY_EN
               duty_act_nxt_s  = bus.duty_in;
               duty_pend_nxt_s = bus.duty_in;
`endif
            end else if (pend_r) begin
               div_act_nxt_s = div_pend_r;
               pend_nxt_s    = 1'b0;
`ifdef CLKDIV_DUTY_EN
               duty_act_nxt_s = duty_pend_r;
`endif
            end else begin
               pend_nxt_s = 1'b0;
            end
         end else begin
            cnt_nxt_s = cnt_r + ONE;
            if (bus.load) begin
               div_pend_nxt_s = bus.div_in;
               pend_nxt_s     = 1'b1;
`ifdef CLKDIV_DUTY_EN
               duty_pend_nxt_s = bus.duty_in;
`endif
            end else begin
               pend_nxt_s = pend_r;
            end
         end
      end else begin
         if (bus.load) begin
            div_act_nxt_s  = bus.div_in;
            div_pend_nxt_s = bus.div_in;
            pend_nxt_s     = 1'b0;
`ifdef CLKDIV_DUTY_EN
            duty_act_nxt_s  = bus.duty_in;
            duty_pend_nxt_s = bus.duty_in;
`endif
            // Shrinking T below a frozen count would skip the wrap; restart instead.
            if (cnt_r > bus.div_in) begin
               cnt_nxt_s = '0;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end else begin
            pend_nxt_s = pend_r;
         end
      end
`ifdef CLKDIV_DUTY_EN
      pwm_nxt_s = (cnt_nxt_s < duty_act_nxt_s);
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r      <= '0;
         div_act_r  <= DEFAULT_DIV;
         div_pend_r <= DEFAULT_DIV;
         pend_r     <= 1'b0;
         tick_r     <= 1'b0;
         sq_r       <= 1'b0;
`ifdef CLKDIV_DUTY_EN
         duty_act_r  <= '0;
         duty_pend_r <= '0;
         pwm_r       <= 1'b0;
`endif
      end else begin
         cnt_r      <= cnt_nxt_s;
         div_act_r  <= div_act_nxt_s;
         div_pend_r <= div_pend_nxt_s;
         pend_r     <= pend_nxt_s;
         tick_r     <= tick_nxt_s;
         sq_r       <= sq_nxt_s;
`ifdef CLKDIV_DUTY_EN
         duty_act_r  <= duty_act_nxt_s;
         duty_pend_r <= duty_pend_nxt_s;
         pwm_r       <= pwm_nxt_s;
`endif
      end
   end

   assign bus.cnt_o  = cnt_r;
   assign bus.tick   = tick_r;
   assign bus.sq_out = sq_r;
   assign bus.pend_o = pend_r;
`ifdef CLKDIV_DUTY_EN
   assign bus.pwm_out = pwm_r;
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised scoreboard bench for prog_clk_divider: a period/wrap-count model predicts every cycle.
module tb_prog_clk_divider;
   localparam int W    = 8;
   localparam int DEF  = 9;
   localparam int TMAX = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prog_clk_divider_if #(.WIDTH(W)) bus ();
   prog_clk_divider #(.WIDTH(W), .DEFAULT_DIV(8'd9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int cnt;
      bit tick;
      bit sq;
      bit pend;
      bit pwm;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   // Reference model: position within the current period, active/pending periods, wrap count.
   int m_cnt, m_T, m_pT, m_duty, m_pduty, m_wraps;
   bit m_pend, m_tick;

   task automatic apply_now(input int d, input int du);
      m_T = d; m_pT = d; m_duty = du; m_pduty = du; m_pend = 1'b0;
   endtask

   task automatic model_step(input bit r, input bit e, input bit c, input bit l,
                             input int d, input int du);
      bit wrap;
      if (!r) begin
         m_cnt = 0; m_T = DEF; m_pT = DEF; m_pend = 0; m_tick = 0; m_wraps = 0;
         m_duty = 0; m_pduty = 0;
      end else if (c) begin
         m_cnt = 0; m_tick = 0; m_wraps = 0;
         if (l) apply_now(d, du);
      end else if (!e) begin
         m_tick = 0;
         if (l) begin
            apply_now(d, du);
            if (m_cnt > m_T) m_cnt = 0;
         end
      end else begin
         wrap   = (m_cnt == m_T);
         m_cnt  = (m_cnt + 1) % (m_T + 1);
         m_tick = wrap;
         if (wrap) begin
            m_wraps++;
            if (l) apply_now(d, du);
            else if (m_pend) begin
               m_T = m_pT; m_duty = m_pduty; m_pend = 0;
            end
         end else if (l) begin
            m_pT = d; m_pduty = du; m_pend = 1;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit e, input bit c, input bit l,
                        input int d, input int du);
      exp_t x;
      @(negedge clk);
      rst_n      = r;
      bus.en     = e;
      bus.clr    = c;
      bus.load   = l;
      bus.div_in = d[W-1:0];
`ifdef CLKDIV_DUTY_EN
      bus.duty_in = du[W-1:0];
`endif
      model_step(r, e, c, l, d, du);
      x.cnt  = m_cnt;
      x.tick = m_tick;
      x.sq   = m_wraps[0];
      x.pend = m_pend;
      x.pwm  = (m_cnt < m_duty);
      sb.push_back(x);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic run_until_cnt(input int v);
      int k;
      k = 0;
      while (m_cnt != v && k < 2000) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
         k++;
      end
   endtask

   task automatic check(input string name, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp_v);
      end
   endtask

   // Monitor: outputs are valid every cycle, so one expectation is retired per edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check("cnt_o",  int'(bus.cnt_o),  x.cnt);
            check("tick",   int'(bus.tick),   int'(x.tick));
            check("sq_out", int'(bus.sq_out), int'(x.sq));
            check("pend_o", int'(bus.pend_o), int'(x.pend));
`ifdef CLKDIV_DUTY_EN
            check("pwm_out", int'(bus.pwm_out), int'(x.pwm));
`endif
         end
      end
   end

   initial begin
      #2000000;
      if (!done) begin
         $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
         $fatal(1, "watchdog");
      end
   end

   initial begin
      int d, du;
      bit r, e, c, l;
      bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0; bus.div_in = '0;
`ifdef CLKDIV_DUTY_EN
      bus.duty_in = '0;
`endif
      rst_n = 1'b0;

      // Default divide-by-10 after reset
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      run(45);

      // Shadowed load of T=3 at cnt=5
      run_until_cnt(5);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
      run(30);

      // T=0 then full-range T
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
      run(12);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, TMAX, 0);
      run(2 * (TMAX + 1) + 20);

      // Freeze at cnt=4 for 7 cycles with T=9
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 9, 0);
      run_until_cnt(0);
      run_until_cnt(4);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      run(20);

      // Reset with a pending load, then clr at cnt=7
      run_until_cnt(2);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 3, 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      run(15);
      run_until_cnt(7);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
      run(15);

      // Frozen load below the held count
      run_until_cnt(8);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 4, 0);
      run(12);

`ifdef CLKDIV_DUTY_EN
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 9, 3);
      run(30);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 9, 0);
      run(25);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 9, 12);
      run(25);
`endif

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 299) != 0);
         e  = ($urandom_range(0, 9) != 0);
         c  = ($urandom_range(0, 39) == 0);
         l  = ($urandom_range(0, 19) == 0);
         d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMAX) : $urandom_range(0, 12);
         du = $urandom_range(0, 14);
         cycle(r, e, c, l, d, du);
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
